// File: rtl/mem_lsu_sb.sv
// MEM-stage load/store unit: posted store buffer draining over a req/ack bus, loads wait for drain.
// Define LSU_FWD_EN to build store-to-load forwarding from the buffer.
//
//  state | meaning
//  IDLE  | accept stores, start loads, drain buffer in background
//  DRAIN | load pending, waiting for the store buffer to empty
//  LREQ  | load read on the bus, waiting for bus_ack
//  LDONE | load_data valid, load_done pulse, pipeline released
module mem_lsu_sb #(
    parameter int ADDR_W   = 32,
    parameter int SB_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_valid,
    input  logic [1:0]        mem_op,
    input  logic [1:0]        mem_size,
    input  logic              mem_sext,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              stall,
    output logic [31:0]       load_data,
    output logic              load_done,
    output logic              adel,
    output logic              ades,
    output logic              sb_empty,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata
);
    localparam int PW = $clog2(SB_DEPTH);

    typedef enum logic [1:0] {IDLE, DRAIN, LREQ, LDONE} state_t;

    state_t state, state_n;

    logic [ADDR_W-3:0] sb_waddr [SB_DEPTH];
    logic [3:0]        sb_be    [SB_DEPTH];
    logic [31:0]       sb_data  [SB_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       count;

    logic        is_load, is_store, misalign, full;
    logic        push, pop, drain_act, fwd_take;
    logic [3:0]  lane_be;
    logic [31:0] lane_data;
    logic        fwd_hit;
    logic [31:0] fwd_data;

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] a,
                                            input logic [1:0] sz, input logic sx);
        logic [31:0] sh;
        logic [15:0] h;
        sh = w >> {a, 3'b000};
        h  = a[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   return sx ? {{24{sh[7]}}, sh[7:0]} : {24'b0, sh[7:0]};
            2'b01:   return sx ? {{16{h[15]}}, h} : {16'b0, h};
            default: return w;
        endcase
    endfunction

    assign is_load  = mem_valid && (mem_op == 2'b01);
    assign is_store = mem_valid && (mem_op == 2'b10);
    assign misalign = (mem_size == 2'b01) ? mem_addr[0] :
                      (mem_size[1] ? (mem_addr[1:0] != 2'b00) : 1'b0);
    assign adel     = is_load && misalign;
    assign ades     = is_store && misalign;
    assign full     = (count == (PW+1)'(SB_DEPTH));
    assign sb_empty = (count == '0);

    always_comb begin
        lane_be   = 4'b1111;
        lane_data = mem_wdata;
        case (mem_size)
            2'b00: begin
                lane_be   = 4'b0001 << mem_addr[1:0];
                lane_data = mem_wdata << {mem_addr[1:0], 3'b000};
            end
            2'b01: begin
                lane_be   = mem_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = mem_wdata << {mem_addr[1], 4'b0000};
            end
            default: ;
        endcase
    end

`ifdef LSU_FWD_EN
    logic [PW-1:0] fwd_idx;

    // Oldest-to-youngest scan so the youngest matching entry decides.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            fwd_idx = rd_ptr + PW'(i);
            if (((PW+1)'(i) < count) && (sb_waddr[fwd_idx] == mem_addr[ADDR_W-1:2])) begin
                fwd_hit  = ((sb_be[fwd_idx] & lane_be) == lane_be);
                fwd_data = sb_data[fwd_idx];
            end
        end
    end
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

    assign fwd_take = (state == IDLE) && is_load && !misalign && fwd_hit;

    always_comb begin
        state_n = state;
        stall   = 1'b0;
        push    = 1'b0;
        case (state)
            IDLE: begin
                if (is_load && !misalign) begin
                    stall   = 1'b1;
                    state_n = fwd_hit ? LDONE : DRAIN;
                end else if (is_store && !misalign) begin
                    // Uses the registered count, so a same-cycle pop never admits the push.
                    if (full) stall = 1'b1;
                    else      push  = 1'b1;
                end
            end
            DRAIN: begin
                stall = 1'b1;
                if (count == '0) state_n = LREQ;
            end
            LREQ: begin
                stall = 1'b1;
                if (bus_ack) state_n = LDONE;
            end
            LDONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign drain_act = (state != LREQ) && (count != '0);
    assign pop       = drain_act && bus_ack;
    assign load_done = (state == LDONE);

    always_comb begin
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_be    = 4'b0000;
        bus_wdata = '0;
        if (state == LREQ) begin
            bus_req  = 1'b1;
            bus_addr = {mem_addr[ADDR_W-1:2], 2'b00};
            bus_be   = 4'b1111;
        end else if (drain_act) begin
            bus_req   = 1'b1;
            bus_we    = 1'b1;
            bus_addr  = {sb_waddr[rd_ptr], 2'b00};
            bus_be    = sb_be[rd_ptr];
            bus_wdata = sb_data[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            sb_waddr[wr_ptr] <= mem_addr[ADDR_W-1:2];
            sb_be[wr_ptr]    <= lane_be;
            sb_data[wr_ptr]  <= lane_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            load_data <= '0;
        end else begin
            state <= state_n;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (fwd_take)
                load_data <= extract(fwd_data, mem_addr[1:0], mem_size, mem_sext);
            else if ((state == LREQ) && bus_ack)
                load_data <= extract(bus_rdata, mem_addr[1:0], mem_size, mem_sext);
        end
    end
endmodule
